// File: rtl/ddr3_rw_arbiter.sv
// rtl/ddr3_rw_arbiter.sv - DDR3 read/write burst arbiter between the FIFO controller and the MIG native UI
//
// Ports:
//   ui_clk, rst_n            MIG user clock (only clock), asynchronous active-low reset
//   init_calib_complete      MIG calibration done; bursts run only once it is high
//   wr_load, rd_load         single-cycle pulses restarting the write/read address at ADDR_MIN
//   rd_enable                level that allows read bursts
//   wfifo_rcount/dout/rden   write-FIFO fill level, first-word-fall-through data, pop
//   rfifo_wcount/din/wren    read-FIFO fill level, push data, push strobe
//   app_*                    MIG native command, write-data and read-return interface
module ddr3_rw_arbiter #(
    parameter int          BURST_LEN   = 64,
    parameter logic [27:0] ADDR_MIN    = 28'd0,
    parameter logic [27:0] ADDR_MAX    = 28'd786432,
    parameter int          RFIFO_DEPTH = 512
) (
    input  logic         ui_clk,
    input  logic         rst_n,
    input  logic         init_calib_complete,
    input  logic         wr_load,
    input  logic         rd_load,
    input  logic         rd_enable,
    input  logic [9:0]   wfifo_rcount,
    input  logic [127:0] wfifo_dout,
    output logic         wfifo_rden,
    input  logic [9:0]   rfifo_wcount,
    output logic [127:0] rfifo_din,
    output logic         rfifo_wren,
    input  logic         app_rdy,
    input  logic         app_wdf_rdy,
    input  logic         app_rd_data_valid,
    input  logic [127:0] app_rd_data,
    output logic         app_en,
    output logic         app_wdf_wren,
    output logic         app_wdf_end,
    output logic [2:0]   app_cmd,
    output logic [27:0]  app_addr,
    output logic [127:0] app_wdf_data,
    output logic [15:0]  app_wdf_mask
);

    typedef enum logic [1:0] {
        WAIT_CALIB = 2'd0,
        IDLE       = 2'd1,
        WRITE      = 2'd2,
        READ       = 2'd3
    } state_t;

    localparam logic [7:0]  LAST_BEAT = 8'(BURST_LEN - 1);
    localparam logic [9:0]  BURST_10  = 10'(BURST_LEN);
    localparam logic [11:0] BURST_12  = 12'(BURST_LEN);
    localparam logic [11:0] DEPTH_12  = 12'(RFIFO_DEPTH);
    localparam logic [27:0] ADDR_LAST = ADDR_MAX - 28'd8;
    localparam logic [2:0]  CMD_WR    = 3'b000;
    localparam logic [2:0]  CMD_RD    = 3'b001;

    state_t       state, state_next;
    logic [27:0]  wr_addr, rd_addr;
    logic [27:0]  wr_addr_next, rd_addr_next;
    logic [27:0]  addr_next;
    logic [2:0]   cmd_next;
    logic [7:0]   beat_cnt;
    logic [10:0]  outstanding;
    logic         last_wr;
    logic         wr_load_pend, rd_load_pend;
    logic         wr_req, rd_req;
    logic         wr_fire, rd_fire;
    logic         last_beat;
    logic [11:0]  rd_need;

    // A read burst is only started if the read FIFO can absorb every word
    // already in flight plus a whole new burst; 12 bits cannot overflow here.
    assign rd_need   = {2'b00, rfifo_wcount} + {1'b0, outstanding} + BURST_12;
    assign rd_req    = rd_enable && (rd_need <= DEPTH_12);
    assign wr_req    = wfifo_rcount >= BURST_10;

    assign wr_fire   = (state == WRITE) && app_rdy && app_wdf_rdy;
    assign rd_fire   = (state == READ) && app_rdy;
    assign last_beat = (beat_cnt == LAST_BEAT);

    assign app_en       = wr_fire || rd_fire;
    assign app_wdf_wren = wr_fire;
    assign app_wdf_end  = wr_fire;
    assign wfifo_rden   = wr_fire;
    assign app_wdf_data = wr_fire ? wfifo_dout : 128'd0;
    assign app_wdf_mask = 16'd0;

    always_comb begin
        state_next = state;
        case (state)
            WAIT_CALIB: begin
                if (init_calib_complete) state_next = IDLE;
            end
            IDLE: begin
                if (!init_calib_complete)  state_next = WAIT_CALIB;
                else if (wr_req && rd_req) state_next = last_wr ? READ : WRITE;
                else if (wr_req)           state_next = WRITE;
                else if (rd_req)           state_next = READ;
            end
            WRITE: begin
                if (wr_fire && last_beat) state_next = IDLE;
            end
            READ: begin
                if (rd_fire && last_beat) state_next = IDLE;
            end
            default: state_next = WAIT_CALIB;
        endcase
    end

    // Pending loads are only applied in IDLE, so a burst never changes
    // address region half way through.
    always_comb begin
        wr_addr_next = wr_addr;
        if ((state == IDLE) && wr_load_pend)
            wr_addr_next = ADDR_MIN;
        else if (wr_fire)
            wr_addr_next = (wr_addr == ADDR_LAST) ? ADDR_MIN : wr_addr + 28'd8;
    end

    always_comb begin
        rd_addr_next = rd_addr;
        if ((state == IDLE) && rd_load_pend)
            rd_addr_next = ADDR_MIN;
        else if (rd_fire)
            rd_addr_next = (rd_addr == ADDR_LAST) ? ADDR_MIN : rd_addr + 28'd8;
    end

    // app_addr/app_cmd are registered copies of what the next state will present.
    always_comb begin
        addr_next = 28'd0;
        cmd_next  = CMD_WR;
        if (state_next == WRITE) begin
            addr_next = wr_addr_next;
        end else if (state_next == READ) begin
            addr_next = rd_addr_next;
            cmd_next  = CMD_RD;
        end
    end

    always_ff @(posedge ui_clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= WAIT_CALIB;
            wr_addr      <= ADDR_MIN;
            rd_addr      <= ADDR_MIN;
            beat_cnt     <= 8'd0;
            outstanding  <= 11'd0;
            last_wr      <= 1'b0;
            wr_load_pend <= 1'b0;
            rd_load_pend <= 1'b0;
            app_addr     <= 28'd0;
            app_cmd      <= CMD_WR;
            rfifo_wren   <= 1'b0;
            rfifo_din    <= 128'd0;
        end else begin
            state    <= state_next;
            wr_addr  <= wr_addr_next;
            rd_addr  <= rd_addr_next;
            app_addr <= addr_next;
            app_cmd  <= cmd_next;

            if (state == IDLE)
                beat_cnt <= 8'd0;
            else if (wr_fire || rd_fire)
                beat_cnt <= beat_cnt + 8'd1;

            if (wr_fire && last_beat)
                last_wr <= 1'b1;
            else if (rd_fire && last_beat)
                last_wr <= 1'b0;

            // A new pulse in the same cycle as an IDLE apply re-arms the flag.
            wr_load_pend <= wr_load || (wr_load_pend && (state != IDLE));
            rd_load_pend <= rd_load || (rd_load_pend && (state != IDLE));

            case ({rd_fire, app_rd_data_valid})
                2'b10:   outstanding <= outstanding + 11'd1;
                2'b01:   outstanding <= outstanding - 11'd1;
                default: outstanding <= outstanding;
            endcase

            rfifo_wren <= app_rd_data_valid;
            rfifo_din  <= app_rd_data;
        end
    end

endmodule

// File: tb/tb_ddr3_rw_arbiter.sv
// tb/tb_ddr3_rw_arbiter.sv - scoreboard testbench for ddr3_rw_arbiter
module tb_ddr3_rw_arbiter;

    localparam int          B       = 16;
    localparam logic [27:0] AMIN    = 28'd0;
    localparam logic [27:0] AMAX    = 28'd192;
    localparam int          DEPTH   = 512;
    localparam int          RET_DLY = 20;

    logic         ui_clk = 1'b0;
    logic         rst_n;
    logic         init_calib_complete;
    logic         wr_load, rd_load, rd_enable;
    logic [9:0]   wfifo_rcount, rfifo_wcount;
    logic [127:0] wfifo_dout;
    logic         wfifo_rden;
    logic [127:0] rfifo_din;
    logic         rfifo_wren;
    logic         app_rdy = 1'b1;
    logic         app_wdf_rdy;
    logic         app_rd_data_valid = 1'b0;
    logic [127:0] app_rd_data = 128'd0;
    logic         app_en, app_wdf_wren, app_wdf_end;
    logic [2:0]   app_cmd;
    logic [27:0]  app_addr;
    logic [127:0] app_wdf_data;
    logic [15:0]  app_wdf_mask;

    typedef struct { logic [27:0] addr; logic [127:0] data; } wexp_t;
    typedef struct { int due; logic [127:0] data; } ret_t;
    typedef struct { int cyc; logic [127:0] data; } rf_t;

    wexp_t       wr_q[$];
    logic [27:0] rd_q[$];
    logic [2:0]  ord_q[$];
    ret_t        ret_q[$];
    rf_t         rf_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int widx = 0, wexp_idx = 0, ridx = 0;
    int wr_fires = 0, rd_fires = 0, rden_cnt = 0, starts = 0;
    int vcnt = 0, start_vcnt = 0, mon_beat = 0, wr_first = 0, wr_last = 0;
    logic [27:0] mwa = AMIN;
    logic [27:0] mra = AMIN;
    logic rdy_toggle = 1'b0;

    ddr3_rw_arbiter #(
        .BURST_LEN(B), .ADDR_MIN(AMIN), .ADDR_MAX(AMAX), .RFIFO_DEPTH(DEPTH)
    ) dut (
        .ui_clk(ui_clk), .rst_n(rst_n), .init_calib_complete(init_calib_complete),
        .wr_load(wr_load), .rd_load(rd_load), .rd_enable(rd_enable),
        .wfifo_rcount(wfifo_rcount), .wfifo_dout(wfifo_dout), .wfifo_rden(wfifo_rden),
        .rfifo_wcount(rfifo_wcount), .rfifo_din(rfifo_din), .rfifo_wren(rfifo_wren),
        .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data_valid(app_rd_data_valid), .app_rd_data(app_rd_data),
        .app_en(app_en), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
        .app_cmd(app_cmd), .app_addr(app_addr), .app_wdf_data(app_wdf_data),
        .app_wdf_mask(app_wdf_mask)
    );

    always #5 ui_clk = ~ui_clk;
    always @(posedge ui_clk) cyc <= cyc + 1;

    always @(posedge ui_clk) begin
        #1;
        app_rdy = rdy_toggle ? ~app_rdy : 1'b1;
    end

    function automatic logic [127:0] wpat(input int i);
        return {4{32'h5A00_0000 + 32'(i)}};
    endfunction

    function automatic logic [127:0] rpat(input int i);
        return {4{32'hA5A5_A5A5}} ^ 128'(i);
    endfunction

    function automatic logic [27:0] next_addr(input logic [27:0] a);
        return (a == AMAX - 28'd8) ? AMIN : a + 28'd8;
    endfunction

    assign wfifo_dout = wpat(widx);

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_wr_burst();
        for (int i = 0; i < B; i++) begin
            wr_q.push_back('{addr: mwa, data: wpat(wexp_idx)});
            wexp_idx++;
            mwa = next_addr(mwa);
        end
    endtask

    task automatic push_rd_burst();
        for (int i = 0; i < B; i++) begin
            rd_q.push_back(mra);
            mra = next_addr(mra);
        end
    endtask

    function automatic int cnt(input int sel);
        case (sel)
            0:       return wr_fires;
            1:       return rd_fires;
            default: return starts;
        endcase
    endfunction

    task automatic wait_cnt(input int sel, input int n, input string tag);
        int k = 0;
        while (cnt(sel) < n && k < 3000) begin
            @(posedge ui_clk); #1;
            k++;
        end
        chk(tag, 128'(cnt(sel) >= n), 128'd1);
    endtask

    task automatic drain(input string tag);
        int k = 0;
        while ((wr_q.size() + rd_q.size() + ret_q.size() + rf_q.size() + ord_q.size()) != 0 && k < 3000) begin
            @(posedge ui_clk); #1;
            k++;
        end
        chk(tag, 128'(wr_q.size() + rd_q.size() + ret_q.size() + rf_q.size() + ord_q.size()), 128'd0);
        repeat (4) @(posedge ui_clk);
        #1;
    endtask

    // Monitor plus MIG read-return model, sampled away from the active edge.
    always @(negedge ui_clk) begin
        if (!rst_n) begin
            mon_beat = 0;
            ret_q.delete();
            rf_q.delete();
            app_rd_data_valid = 1'b0;
        end else begin
            if (!app_rdy) chk("en_gated", 128'(app_en), 128'd0);
            if (wfifo_rden) rden_cnt++;
            if (app_en) begin
                automatic bit is_start = (mon_beat == 0);
                if (is_start) begin
                    starts++;
                    start_vcnt = vcnt;
                    if (ord_q.size() > 0) chk("order", 128'(app_cmd), 128'(ord_q.pop_front()));
                end
                mon_beat = (mon_beat == B - 1) ? 0 : mon_beat + 1;
                if (app_cmd == 3'b000) begin
                    wr_fires++;
                    if (is_start) wr_first = cyc;
                    wr_last = cyc;
                    chk("wr_strobes", 128'({app_wdf_wren, app_wdf_end, wfifo_rden}), 128'd7);
                    if (wr_q.size() == 0) begin
                        chk("wr_extra", 128'd1, 128'd0);
                    end else begin
                        automatic wexp_t e = wr_q.pop_front();
                        chk("wr_addr", 128'(app_addr), 128'(e.addr));
                        chk("wr_data", app_wdf_data, e.data);
                    end
                    widx++;
                end else begin
                    rd_fires++;
                    chk("rd_cmd", 128'(app_cmd), 128'd1);
                    chk("rd_strobes", 128'({app_wdf_wren, wfifo_rden}), 128'd0);
                    if (rd_q.size() == 0) begin
                        chk("rd_extra", 128'd1, 128'd0);
                    end else begin
                        chk("rd_addr", 128'(app_addr), 128'(rd_q.pop_front()));
                    end
                    ret_q.push_back('{due: cyc + RET_DLY, data: rpat(ridx)});
                    ridx++;
                end
            end
            if (rfifo_wren) begin
                if (rf_q.size() == 0) begin
                    chk("rf_extra", 128'd1, 128'd0);
                end else begin
                    automatic rf_t r = rf_q.pop_front();
                    chk("rf_data", rfifo_din, r.data);
                    chk("rf_lat", 128'(cyc), 128'(r.cyc));
                end
            end
            app_rd_data_valid = 1'b0;
            if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
                automatic ret_t rt = ret_q.pop_front();
                app_rd_data_valid = 1'b1;
                app_rd_data = rt.data;
                rf_q.push_back('{cyc: cyc + 1, data: rt.data});
                vcnt++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b, s0;
        rst_n = 1'b0; init_calib_complete = 1'b0; wr_load = 1'b0; rd_load = 1'b0;
        rd_enable = 1'b0; wfifo_rcount = 10'd0; rfifo_wcount = 10'd0; app_wdf_rdy = 1'b1;
        repeat (3) @(posedge ui_clk);
        #1;
        chk("rst_app_en", 128'(app_en), 128'd0);
        chk("rst_wdf", 128'({app_wdf_wren, app_wdf_end, wfifo_rden, rfifo_wren}), 128'd0);
        chk("rst_cmd", 128'(app_cmd), 128'd0);
        chk("rst_addr", 128'(app_addr), 128'd0);
        chk("rst_wdata", app_wdf_data, 128'd0);
        chk("rst_rfdin", rfifo_din, 128'd0);
        chk("rst_mask", 128'(app_wdf_mask), 128'd0);
        rst_n = 1'b1;

        // single write burst after calibration
        wfifo_rcount = 10'(B);
        repeat (10) @(posedge ui_clk);
        #1;
        chk("calib_hold", 128'(wr_fires), 128'd0);
        push_wr_burst();
        init_calib_complete = 1'b1;
        wait_cnt(0, 1, "t1_start");
        wfifo_rcount = 10'd0;
        drain("t1_drain");
        chk("t1_rden", 128'(rden_cnt), 128'(B));
        chk("t1_beats", 128'(wr_fires), 128'(B));
        chk("t1_consec", 128'(wr_last - wr_first), 128'(B - 1));

        // app_rdy toggling, second burst wraps 184 -> 0
        rdy_toggle = 1'b1;
        push_wr_burst();
        wfifo_rcount = 10'(B);
        wait_cnt(0, B + 1, "t2_start");
        wfifo_rcount = 10'd0;
        drain("t2_drain");
        rdy_toggle = 1'b0;
        chk("t2_rden", 128'(rden_cnt), 128'(2 * B));

        // both requests held: R,W,R,W (last completed burst was a write)
        ord_q.push_back(3'b001); ord_q.push_back(3'b000);
        ord_q.push_back(3'b001); ord_q.push_back(3'b000);
        push_rd_burst(); push_wr_burst(); push_rd_burst(); push_wr_burst();
        s0 = starts;
        rd_enable = 1'b1;
        wfifo_rcount = 10'(B);
        wait_cnt(2, s0 + 4, "t3_starts");
        rd_enable = 1'b0;
        wfifo_rcount = 10'd0;
        drain("t3_drain");

        // read-FIFO headroom: 497 + 16 > 512 blocks
        rd_enable = 1'b1;
        rfifo_wcount = 10'd497;
        b = rd_fires;
        repeat (40) @(posedge ui_clk);
        #1;
        chk("rd_block497", 128'(rd_fires - b), 128'd0);

        // outstanding reads gate the second burst until returns arrive
        push_rd_burst(); push_rd_burst();
        s0 = starts;
        rfifo_wcount = 10'd481;
        wait_cnt(2, s0 + 2, "t4_starts");
        rd_enable = 1'b0;
        chk("rd_gate", 128'(start_vcnt >= 1), 128'd1);
        drain("t4_drain");

        // 496 + 0 + 16 == 512 is allowed; also shows outstanding back at 0
        push_rd_burst();
        b = rd_fires;
        rfifo_wcount = 10'd496;
        rd_enable = 1'b1;
        wait_cnt(1, b + 1, "t5_start");
        rd_enable = 1'b0;
        drain("t5_drain");
        chk("t5_reads", 128'(rd_fires - b), 128'(B));

        // wr_load mid-burst: next burst restarts at ADDR_MIN
        push_wr_burst();
        s0 = starts;
        b = wr_fires;
        wfifo_rcount = 10'(B);
        wait_cnt(0, b + 1, "t6_start");
        wr_load = 1'b1;
        @(posedge ui_clk); #1;
        wr_load = 1'b0;
        mwa = AMIN;
        push_wr_burst();
        wait_cnt(2, s0 + 2, "t6_starts");
        wfifo_rcount = 10'd0;
        drain("t6_drain");

        // asynchronous reset in the middle of a read burst
        rfifo_wcount = 10'd0;
        push_rd_burst();
        b = rd_fires;
        rd_enable = 1'b1;
        wait_cnt(1, b + 4, "t7_start");
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_en", 128'(app_en), 128'd0);
        chk("rst_mid_addr", 128'(app_addr), 128'd0);
        chk("rst_mid_cmd", 128'(app_cmd), 128'd0);
        chk("rst_mid_strb", 128'({rfifo_wren, wfifo_rden}), 128'd0);
        rd_q.delete();
        rd_enable = 1'b0;
        repeat (2) @(posedge ui_clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(posedge ui_clk);
        #1;
        chk("post_rst_idle", 128'(app_en), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
